// File: rtl/mem_bus_if.sv
// Single-request Avalon-MM master front end feeding the multicycle decoder.
// Optional waitrequest timeout is enabled with the MEM_IF_TIMEOUT_EN macro.
module mem_bus_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_instr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] Instr,
  output logic [31:0] data_out,
  output logic        resp_valid,
  output logic        resp_err,
  output logic        stall
);

  // state  | meaning
  // IDLE   | ready for a request
  // BUS    | Avalon transfer in flight, waiting for waitrequest low
  // RESP   | one-cycle completion pulse
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        wr_q, wr_d;
  logic        instr_q, instr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] address_q, address_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic        err_q, err_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] dout_q, dout_d;

  logic        is_byte, is_half, misalign;
  logic [3:0]  lane_be;
  logic [31:0] lane_wd;
  logic [31:0] rd_shift, load_ext;
  logic [15:0] rd_half;

`ifdef MEM_IF_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^16'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    is_byte  = (req_size == 2'b00);
    is_half  = (req_size == 2'b01);
    misalign = (is_half & req_addr[0]) | (req_size[1] & (req_addr[1:0] != 2'b00));
    if (is_byte) begin
      lane_be = 4'b1000 >> req_addr[1:0];
      lane_wd = {24'b0, req_wdata[7:0]} << {~req_addr[1:0], 3'b000};
    end else if (is_half) begin
      lane_be = req_addr[1] ? 4'b0011 : 4'b1100;
      lane_wd = req_addr[1] ? {16'b0, req_wdata[15:0]} : {req_wdata[15:0], 16'b0};
    end else begin
      lane_be = 4'b1111;
      lane_wd = req_wdata;
    end
  end

  // Big-endian lanes: byte offset k lives in bits [31-8k : 24-8k].
  always_comb begin
    rd_shift = readdata >> {~off_q, 3'b000};
    rd_half  = off_q[1] ? readdata[15:0] : readdata[31:16];
    case (size_q)
      2'b00:   load_ext = signed_q ? {{24{rd_shift[7]}}, rd_shift[7:0]} : {24'b0, rd_shift[7:0]};
      2'b01:   load_ext = signed_q ? {{16{rd_half[15]}}, rd_half} : {16'b0, rd_half};
      default: load_ext = readdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    instr_d      = instr_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    err_d        = err_q;
    ir_d         = ir_q;
    dout_d       = dout_q;
`ifdef MEM_IF_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d         = req_write;
          instr_d      = req_instr & ~req_write;
          size_d       = req_size;
          signed_d     = req_signed;
          off_d        = req_addr[1:0];
          address_d    = {req_addr[31:2], 2'b00};
          writedata_d  = lane_wd;
          byteenable_d = lane_be;
          err_d        = misalign;
          state_d      = misalign ? S_RESP : S_BUS;
`ifdef MEM_IF_TIMEOUT_EN
          cnt_d        = 16'd0;
`endif
        end
      end
      S_BUS: begin
        if (!waitrequest) begin
          if (!wr_q) begin
            if (instr_q) ir_d = readdata;
            else         dout_d = load_ext;
          end
          state_d = S_RESP;
        end
`ifdef MEM_IF_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == 16'(TIMEOUT_CYCLES)) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      instr_q      <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      off_q        <= 2'b00;
      address_q    <= 32'b0;
      writedata_q  <= 32'b0;
      byteenable_q <= 4'b0;
      err_q        <= 1'b0;
      ir_q         <= 32'b0;
      dout_q       <= 32'b0;
`ifdef MEM_IF_TIMEOUT_EN
      cnt_q        <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      instr_q      <= instr_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      err_q        <= err_d;
      ir_q         <= ir_d;
      dout_q       <= dout_d;
`ifdef MEM_IF_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign stall      = ~req_ready;
  assign read       = (state_q == S_BUS) & ~wr_q;
  assign write      = (state_q == S_BUS) & wr_q;
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = resp_valid & err_q;
  assign address    = address_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign Instr      = ir_q;
  assign data_out   = dout_q;

endmodule

// File: doc/mem_bus_if.md
# mem_bus_if

Memory-bus front end sitting directly upstream of the multicycle decoder. It accepts one read or write request at a time from the datapath (instruction fetch or load/store), runs it as an Avalon-MM master transfer honouring `waitrequest`, and returns the result. Instruction reads are latched into the instruction register that drives the decoder's `Instr` input; data reads are lane-extracted and extended. A `stall` flag tells the decoder that the bus is busy.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum consecutive `waitrequest` cycles before abort. Used only with `MEM_IF_TIMEOUT_EN`; legal range 1..65535.

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load/fetch.
- `req_instr`  in  1  1 = instruction fetch; the result goes to `Instr`. Ignored when `req_write` = 1.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `req_signed`  in  1  1 = sign-extend narrow loads, 0 = zero-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `address`  out  32  Avalon word address: `{req_addr[31:2], 2'b00}`.
- `read`  out  1  Avalon read.
- `write`  out  1  Avalon write.
- `writedata`  out  32  store data shifted onto its byte lanes.
- `byteenable`  out  4  lane enables.
- `waitrequest`  in  1  Avalon slave stall.
- `readdata`  in  32  valid in any cycle where `read && !waitrequest`.
- `Instr`  out  32  instruction register.
- `data_out`  out  32  extended load result.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  qualified by `resp_valid`; indicates misalignment or timeout.
- `stall`  out  1  equals `!req_ready`.

## Operation
- States: IDLE, BUS, RESP.
  - IDLE: on an accepted request, latch all request fields and go to BUS. If the access is misaligned (half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0), go to RESP with the error flag set instead; no bus cycle is issued.
  - BUS: drive `read` or `write` from the latched fields. When `waitrequest` = 0, the transfer completes: capture the result and go to RESP.
  - RESP: `resp_valid` = 1 for exactly one cycle, then return to IDLE.
- Lane mapping is big-endian. Byte offset k uses lane 3−k: `byteenable` bit 3−k and bits [31−8k : 24−8k].
  - Half at offset 0 → `byteenable` 1100, bits [31:16].
  - Half at offset 2 → `byteenable` 0011, bits [15:0].
  - Word → `byteenable` 1111.
- `writedata`: the narrow value is replicated or shifted onto the selected lanes. Unselected lanes are don't-care but must be driven to 0.
- Load result: the selected lanes are extracted, then sign- or zero-extended to 32 bits per `req_signed`.
- Instruction fetch: the full 32-bit `readdata` is written to `Instr`; `data_out` is unchanged.
- Data load: `data_out` is updated; `Instr` is unchanged.
- Store: neither register is updated.
- On error, neither `Instr` nor `data_out` is updated.
- `req_valid` in non-IDLE states is ignored; there is no queueing.

## Timing
- Reset values: state IDLE, `req_ready` = 1, `stall` = 0. `read`, `write`, `resp_valid`, `resp_err` = 0. `address`, `writedata`, `byteenable`, `Instr` (0 = nop), `data_out` = 0.
- Minimum latency, aligned access with `waitrequest` low:
  - accept at edge 0;
  - `read`/`write` high in cycle 1;
  - `resp_valid` in cycle 2.
- Each `waitrequest` cycle adds one cycle of latency. Address, data, enables, and `read`/`write` stay stable throughout.
- Misaligned access: `resp_valid`/`resp_err` in cycle 1; `read` and `write` never assert.
- `readdata` is sampled only on the edge that ends a BUS cycle with `waitrequest` = 0.
- Reset mid-transfer (`Rst` low): `read`/`write` drop asynchronously, with no response. `Instr` returns to 0.
- `read` and `write` are never high simultaneously.

## Configuration
- `MEM_IF_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to BUS and increments on each BUS cycle with `waitrequest` = 1.
  - When the count reaches `TIMEOUT_CYCLES`, `read`/`write` drop next cycle and the block goes to RESP with `resp_err` = 1. No register is updated.
- Not defined: the counter is absent and BUS waits indefinitely. `resp_err` reports misalignment only.

## Test plan
- Fetch from 0x0000_0040, `waitrequest` low, `readdata` = 0x2408_0005 → `read` high in cycle 1, `Instr` = 0x2408_0005 and `resp_valid` in cycle 2, `data_out` unchanged.
- Signed byte load at 0x103, `readdata` = 0x1122_3380, `waitrequest` high for 3 cycles → `address` = 0x100 held stable for 4 cycles, `data_out` = 0xFFFF_FF80, `resp_valid` in cycle 5.
- Half store, `req_wdata` = 0xABCD at 0x202 → `byteenable` = 0011, `writedata[15:0]` = 0xABCD, `write` for one cycle, `resp_err` = 0.
- Word load at 0x105 → no `read`, `resp_valid` = `resp_err` = 1 in cycle 1, `data_out` unchanged.
- `Rst` low while `read` is held by `waitrequest` → `read` = 0 immediately, `Instr` = 0, `req_ready` = 1 after release.
- With `MEM_IF_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, `waitrequest` held high → `read` drops after 4 wait cycles, `resp_err` = 1, `Instr` unchanged.
